// File: rtl/bank_seq_pkg.sv
// Shared types and constants for the 6509-style bank sequencer.
// The state encoding is visible on the debug port, so the values are fixed.
package bank_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPND  = 3'd1,
    PTRL  = 3'd2,
    PTRH  = 3'd3,
    DATA1 = 3'd4,
    DATA2 = 3'd5
  } state_t;

  localparam logic [7:0]  OPC_LDA_IY_DEF   = 8'hB1;
  localparam logic [7:0]  OPC_STA_IY_DEF   = 8'h91;
  localparam logic [3:0]  BANK_RESET_DEF   = 4'hF;
  localparam logic [14:0] BANK_REG_ADDR_HI = 15'h0000;

  // True for $0000/$0001, the two bank registers.
  function automatic logic is_bank_reg(input logic [15:0] addr);
    return (addr[15:1] == BANK_REG_ADDR_HI);
  endfunction

endpackage

// File: rtl/bank_reg.sv
// 4-bit bank register with write enable and asynchronous active-high reset.
module bank_reg #(
  parameter logic [3:0] RESET_VAL = 4'hF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_q;

  // NOTE: clocked state is always updated with non-blocking '<=' so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= RESET_VAL;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bank_sequencer.sv
// Bank controller letting a 6502 stand in for a 6509: owns the $0000/$0001
// bank registers and steers address_bank per bus cycle of (zp),Y loads/stores.
module bank_sequencer
  import bank_seq_pkg::*;
#(
  parameter logic [3:0] BANK_RESET = BANK_RESET_DEF,
  parameter logic [7:0] OPC_LDA_IY = OPC_LDA_IY_DEF,
  parameter logic [7:0] OPC_STA_IY = OPC_STA_IY_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        phi2,
  input  logic        rdy,
  input  logic        sync,
  input  logic        r_w,
  input  logic [15:0] address_cpu,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [3:0]  address_bank,
  output logic        sel_indirect,
  output logic [2:0]  state
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_is_sta;
  logic       w_is_sta_nxt;

  logic       w_adv;
  logic       w_reg_hit;
  logic       w_we0;
  logic       w_we1;
  logic       w_is_iy_opc;
  logic [3:0] w_bank0;
  logic [3:0] w_bank1;

  // NMOS 6502 ignores RDY on write cycles, so writes always advance.
  assign w_adv       = rdy | ~r_w;
  assign w_reg_hit   = is_bank_reg(address_cpu);
  assign w_we0       = w_adv & w_reg_hit & ~r_w & ~address_cpu[0];
  assign w_we1       = w_adv & w_reg_hit & ~r_w &  address_cpu[0];
  assign w_is_iy_opc = (data_in == OPC_LDA_IY) || (data_in == OPC_STA_IY);

  bank_reg #(.RESET_VAL(BANK_RESET)) u_bank0 (
    .i_clk (clock),
    .i_rst (reset),
    .i_we  (w_we0),
    .i_d   (data_in[3:0]),
    .o_q   (w_bank0)
  );

  bank_reg #(.RESET_VAL(BANK_RESET)) u_bank1 (
    .i_clk (clock),
    .i_rst (reset),
    .i_we  (w_we1),
    .i_d   (data_in[3:0]),
    .o_q   (w_bank1)
  );

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path through the block leaves a latch behind.
  always_comb begin
    w_state_nxt  = r_state;
    w_is_sta_nxt = r_is_sta;
    if (w_adv) begin
      if (sync) begin
        // An opcode fetch resyncs from any state, aborting a stale sequence.
        if (w_is_iy_opc) begin
          w_state_nxt  = OPND;
          w_is_sta_nxt = (data_in == OPC_STA_IY);
        end else begin
          w_state_nxt  = IDLE;
        end
      end else begin
        unique case (r_state)
          IDLE:    w_state_nxt = IDLE;
          OPND:    w_state_nxt = PTRL;
          PTRL:    w_state_nxt = PTRH;
          PTRH:    w_state_nxt = DATA1;
          DATA1:   w_state_nxt = DATA2;
          DATA2:   w_state_nxt = IDLE;
          default: w_state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_is_sta <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_is_sta <= w_is_sta_nxt;
    end
  end

  // In DATA2 a load is either a page-cross fix-up (sync=0) or already the
  // next opcode fetch (sync=1); a store's DATA2 is always its write cycle.
  always_comb begin
    sel_indirect = 1'b0;
    unique case (r_state)
      DATA1:   sel_indirect = 1'b1;
      DATA2:   sel_indirect = r_is_sta | ~sync;
      default: sel_indirect = 1'b0;
    endcase
  end

  assign address_bank = sel_indirect ? w_bank1 : w_bank0;
  assign state        = r_state;

  assign data_oe  = ~reset & r_w & phi2 & w_reg_hit;
  assign data_out = {4'hF, (address_cpu[0] ? w_bank1 : w_bank0)};

endmodule
